// File: rtl/booth_r4_seq_mac.sv
// Sequential radix-4 Booth multiply-accumulate stage.
// One operand pair per input handshake, one Booth digit retired per clock,
// the finished 2W-bit product added into a wrapping ACC_W-bit accumulator.
module booth_r4_seq_mac #(
   parameter int unsigned W     = 8,
   parameter int unsigned ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             busy
);

   localparam int unsigned DIGITS = W / 2;
   localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PP_W   = W + 1;
   localparam int unsigned SUM_W  = W + 2;
   localparam int unsigned LO_W   = SUM_W / 2;
   localparam int unsigned HI_W   = SUM_W - LO_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [W-1:0]       r_a;
   logic [W:0]         r_mq;        // multiplier with b[-1]=0 appended, shifts right 2 per digit
   logic [SUM_W-1:0]   r_hi;        // running upper part of the product, aligned to the current digit
   logic [W-1:0]       r_lo;        // retired low product bits, filled from the top
   logic [CNT_W-1:0]   r_cnt;
   logic               r_clr;
   logic [ACC_W-1:0]   r_acc;
   logic               r_out_valid;
   logic               r_in_ready;
   logic               r_busy;

   logic               w_zero;
   logic               w_neg;
   logic               w_two;
   logic [PP_W-1:0]    w_mag;
   logic [PP_W-1:0]    w_pp;
   logic               w_cin;
   logic [SUM_W-1:0]   w_y;
   logic [LO_W:0]      w_lo_sum;
   logic [HI_W-1:0]    w_hi_sum0;
   logic [HI_W-1:0]    w_hi_sum1;
   logic [SUM_W-1:0]   w_sum;
   logic [2*W-1:0]     w_prod;
   logic [ACC_W-1:0]   w_prod_ext;
   logic               w_last;

   // Booth recoding of the current multiplier triplet {b[2i+1], b[2i], b[2i-1]}
   always_comb begin
      w_zero = 1'b0;
      w_neg  = 1'b0;
      w_two  = 1'b0;
      case (r_mq[2:0])
         3'b000, 3'b111: w_zero = 1'b1;
         3'b001, 3'b010: w_two  = 1'b0;
         3'b011:         w_two  = 1'b1;
         3'b100: begin
            w_neg = 1'b1;
            w_two = 1'b1;
         end
         3'b101, 3'b110: w_neg = 1'b1;
         default:        w_zero = 1'b1;
      endcase
   end

   // Partial product: a or 2a, ones-complemented with carry-in for negative digits.
   // Complementing inside W+1 bits and sign-extending afterwards keeps -2*(-2^(W-1)) exact.
   assign w_mag = w_two ? {r_a, 1'b0} : {r_a[W-1], r_a};
   assign w_pp  = w_zero ? '0 : (w_neg ? ~w_mag : w_mag);
   assign w_cin = w_neg & ~w_zero;
   assign w_y   = {w_pp[PP_W-1], w_pp};

   // Carry-select add: low half ripples, high half precomputed for both carries
   assign w_lo_sum  = {1'b0, r_hi[LO_W-1:0]} + {1'b0, w_y[LO_W-1:0]} + (LO_W+1)'(w_cin);
   assign w_hi_sum0 = r_hi[SUM_W-1:LO_W] + w_y[SUM_W-1:LO_W];
   assign w_hi_sum1 = r_hi[SUM_W-1:LO_W] + w_y[SUM_W-1:LO_W] + HI_W'(1);
   assign w_sum     = {(w_lo_sum[LO_W] ? w_hi_sum1 : w_hi_sum0), w_lo_sum[LO_W-1:0]};

   assign w_prod     = {r_hi[W-1:0], r_lo};
   assign w_prod_ext = ACC_W'($signed(w_prod));
   assign w_last     = (r_cnt == CNT_W'(DIGITS - 1));

   // Control FSM and datapath registers with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_mq        <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_cnt       <= '0;
         r_clr       <= 1'b0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_mq       <= {b, 1'b0};
                  r_clr      <= acc_clr;
                  r_hi       <= '0;
                  r_lo       <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_CALC;
               end
            end
            S_CALC: begin
               r_hi  <= {{2{w_sum[SUM_W-1]}}, w_sum[SUM_W-1:2]};
               r_lo  <= {w_sum[1:0], r_lo[W-1:2]};
               r_mq  <= {2'b00, r_mq[W:2]};
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               r_acc       <= (r_clr ? '0 : r_acc) + w_prod_ext;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign acc_out   = r_acc;
   assign busy      = r_busy;

endmodule

// File: tb/tb_booth_r4_seq_mac.sv
// Directed bench for booth_r4_seq_mac (W=8, ACC_W=20).
module tb_booth_r4_seq_mac;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        acc_clr;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] acc_out;
   logic        busy;

   int errors;
   int checks;
   logic [19:0] m_acc;

   booth_r4_seq_mac #(.W(8), .ACC_W(20)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits for in_ready, presents one operand pair, returns #1 after the accepting edge
   task automatic start_op(input logic signed [7:0] ia, input logic signed [7:0] ib, input logic iclr);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL start_op in_ready: got %b expected 1", in_ready);
      end
      in_valid = 1'b1;
      a        = ia;
      b        = ib;
      acc_clr  = iclr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      acc_clr  = 1'($urandom);
   endtask

   // Full operation with latency check, optional DONE stall, then release
   task automatic run_op(input logic signed [7:0] ia, input logic signed [7:0] ib, input logic iclr,
                         input int stall, input logic [19:0] exp, input string name);
      int lat;
      out_ready = 1'b0;
      start_op(ia, ib, iclr);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL %s latency: got %0d expected 5", name, lat);
      end
      checks++;
      if (acc_out !== exp) begin
         errors++;
         $display("FAIL %s acc_out: got %0d expected %0d (a=%0d b=%0d clr=%0b)",
                  name, $signed(acc_out), $signed(exp), ia, ib, iclr);
      end
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || acc_out !== exp) begin
            errors++;
            $display("FAIL %s stall hold: out_valid=%b acc_out=%0d expected 1/%0d",
                     name, out_valid, $signed(acc_out), $signed(exp));
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (acc_out !== 20'd0) begin errors++; $display("FAIL reset acc_out: got %0d expected 0", acc_out); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      start_op(8'sd3, 8'sd5, 1'b1);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic calc flags: busy=%b in_ready=%b expected 1/0", busy, in_ready);
      end
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL basic latency: got %0d expected 5", lat); end
      checks++;
      if (acc_out !== 20'd15) begin errors++; $display("FAIL basic acc_out: got %0d expected 15", acc_out); end
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic return: in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_signed();
      run_op(-8'sd128, -8'sd128, 1'b1, 0, 20'd16384, "signed_minmin");
      run_op(-8'sd128, 8'sd127, 1'b0, 0, 20'd128, "signed_minmax");
      run_op(8'sd7, -8'sd86, 1'b0, 1, 20'(-474), "signed_aa");
   endtask

   task automatic test_wrap();
      run_op(-8'sd128, -8'sd128, 1'b1, 0, 20'd16384, "wrap_first");
      for (int k = 1; k < 64; k++) begin
         run_op(-8'sd128, -8'sd128, 1'b0, 0, 20'(16384 * (k + 1)), "wrap_step");
      end
      run_op(-8'sd128, -8'sd128, 1'b0, 0, 20'd16384, "wrap_after");
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      start_op(-8'sd5, 8'sd9, 1'b1);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (acc_out !== 20'(-45)) begin
         errors++;
         $display("FAIL bp result: got %0d expected -45", $signed(acc_out));
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid = ~k[0];
         a        = 8'd100;
         b        = 8'd100;
         acc_clr  = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 20'(-45)) begin
            errors++;
            $display("FAIL bp hold: out_valid=%b in_ready=%b acc_out=%0d expected 1/0/-45",
                     out_valid, in_ready, $signed(acc_out));
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 20'(-45)) begin
         errors++;
         $display("FAIL bp release: in_ready=%b out_valid=%b acc_out=%0d expected 1/0/-45",
                  in_ready, out_valid, $signed(acc_out));
      end
      run_op(8'sd1, 8'sd1, 1'b0, 0, 20'(-44), "bp_follow");
   endtask

   task automatic test_back_to_back();
      int hits[$];
      out_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         if (c == 0) begin
            in_valid = 1'b1;
            a        = 8'd1;
            b        = 8'd1;
            acc_clr  = 1'b1;
         end
         if (in_ready) hits.push_back(c);
      end
      in_valid = 1'b0;
      checks++;
      if (hits.size() !== 4) begin
         errors++;
         $display("FAIL b2b accept count: got %0d expected 4", hits.size());
      end else begin
         checks++;
         if (hits[1] - hits[0] !== 7 || hits[2] - hits[1] !== 7) begin
            errors++;
            $display("FAIL b2b spacing: got %0d,%0d expected 7,7", hits[1] - hits[0], hits[2] - hits[1]);
         end
      end
      #1;
      checks++;
      if (acc_out !== 20'd1) begin errors++; $display("FAIL b2b acc_out: got %0d expected 1", acc_out); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      start_op(8'sd100, 8'sd100, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (acc_out !== 20'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid async: acc_out=%0d out_valid=%b in_ready=%b busy=%b expected 0/0/1/0",
                  acc_out, out_valid, in_ready, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(8'sd2, 8'sd3, 1'b0, 0, 20'd6, "rstmid_next");
   endtask

   task automatic test_sweep();
      int vals[10] = '{-128, -127, -86, -1, 0, 1, 2, 3, 85, 127};
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 10; j++) begin
            run_op(8'(vals[i]), 8'(vals[j]), 1'b1, 0, 20'(vals[i] * vals[j]), "sweep");
         end
      end
   endtask

   task automatic test_random();
      logic signed [7:0] ra;
      logic signed [7:0] rb;
      logic              rc;
      int                st;
      m_acc = 20'd0;
      for (int k = 0; k < 200; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = (k == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         st = $urandom_range(0, 3);
         m_acc = (rc ? 20'd0 : m_acc) + 20'(int'(ra) * int'(rb));
         run_op(ra, rb, rc, st, m_acc, "random");
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = 8'd0;
      b         = 8'd0;
      acc_clr   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
